// File: rtl/dff_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter_pkg
//   Shared definitions for the round-robin shared-word arbiter:
//   - FSM state encoding (IDLE / GRANT / DONE; 2'b11 is unused)
//   - default sizing constants for the arbiter and its storage register
// -----------------------------------------------------------------------------
package dff_bank_arbiter_pkg;

   // Arbiter FSM states. The fourth code (2'b11) is never entered on purpose
   // and is recovered to IDLE by the arbiter.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_GRANT = 2'b01,
      ARB_DONE  = 2'b10
   } arb_state_e;

   // Default geometry: four requesters sharing one byte.
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 8;
   localparam int DEF_IDX_W   = 2;

endpackage : dff_bank_arbiter_pkg

// File: rtl/dff_bank_arbiter_shared_word_reg.sv
// -----------------------------------------------------------------------------
// shared_word_reg
//   WIDTH-bit storage word with load enable and synchronous active-low clear.
//   Ports:
//     clock : posedge clock
//     clear : synchronous active-low clear (word goes to zero)
//     load  : when high, d is captured at the next posedge
//     d     : data to capture
//     q     : registered word contents
// -----------------------------------------------------------------------------
module shared_word_reg
   import dff_bank_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] word_q;

   // Next word: capture d on load, otherwise hold.
   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = d;
      end else begin
         word_d = word_q;
      end
   end

   // Word register with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!clear) begin
         word_q <= {WIDTH{1'b0}};
      end else begin
         word_q <= word_d;
      end
   end

   assign q = word_q;

endmodule : shared_word_reg

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//   Round-robin arbiter sharing one WIDTH-bit register among NUM_REQ
//   requesters. A winner is granted, its write data is loaded into the shared
//   word and acknowledged with a one-cycle pulse, then priority rotates to the
//   requester after the winner. At most one write every three cycles.
//   Ports:
//     clock : single clock, all state changes on posedge
//     clear : synchronous active-low reset
//     req   : level request per requester, held until its ack is seen
//     wdata : requester i data at wdata[i*WIDTH +: WIDTH]
//     gnt   : one-hot grant, zero when idle (registered)
//     ack   : one-cycle pulse, requester's data was loaded (registered)
//     q     : shared register contents (registered)
//     owner : index of current / last granted requester (registered)
//     busy  : high whenever the FSM is not IDLE (decoded from state register)
// -----------------------------------------------------------------------------
module dff_bank_arbiter
   import dff_bank_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       ack,
   output logic [WIDTH-1:0]         q,
   output logic [IDX_W-1:0]         owner,
   output logic                     busy
);

   // One-hot vector with only bit idx set.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (idx == IDX_W'(i)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Successor index, wrapping NUM_REQ-1 back to 0 (NUM_REQ need not be a
   // power of two, so plain overflow is not enough).
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] n;
      if (idx == IDX_W'(NUM_REQ - 1)) begin
         n = {IDX_W{1'b0}};
      end else begin
         n = idx + IDX_W'(1);
      end
      return n;
   endfunction

   // First requesting index found scanning p, p+1, ... modulo NUM_REQ.
   // Only meaningful when at least one request bit is set.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] sel;
      logic             found;
      int               pos;
      sel   = p;
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         pos = (int'(p) + off) % NUM_REQ;
         if (!found && r[pos]) begin
            found = 1'b1;
            sel   = IDX_W'(pos);
         end
      end
      return sel;
   endfunction

   // Write data word of requester idx.
   function automatic logic [WIDTH-1:0] word_of(input logic [NUM_REQ*WIDTH-1:0] w,
                                                input logic [IDX_W-1:0]         idx);
      logic [WIDTH-1:0] v;
      v = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (idx == IDX_W'(i)) begin
            v = w[i*WIDTH +: WIDTH];
         end
      end
      return v;
   endfunction

   arb_state_e         state_d, state_q;
   logic [IDX_W-1:0]   ptr_d,   ptr_q;
   logic [IDX_W-1:0]   owner_d, owner_q;
   logic [NUM_REQ-1:0] gnt_d,   gnt_q;
   logic [NUM_REQ-1:0] ack_d,   ack_q;

   logic               any_req_s;
   logic [IDX_W-1:0]   winner_s;
   logic               owner_req_s;
   logic [WIDTH-1:0]   owner_word_s;
   logic               load_s;

   // Arbitration inputs: round-robin winner and the current owner's request/data.
   always_comb begin
      any_req_s    = |req;
      winner_s     = rr_pick(req, ptr_q);
      owner_req_s  = |(req & onehot(owner_q));
      owner_word_s = word_of(wdata, owner_q);
   end

   // FSM next state, grant/ack/owner/pointer updates and word load enable.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      ack_d   = ack_q;
      load_s  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (any_req_s) begin
               gnt_d   = onehot(winner_s);
               owner_d = winner_s;
               state_d = ARB_GRANT;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (owner_req_s) begin
               load_s  = 1'b1;
               ack_d   = onehot(owner_q);
               state_d = ARB_DONE;
            end else begin
               // Request withdrawn before the load: abort without writing,
               // and still rotate past the aborted requester.
               gnt_d   = {NUM_REQ{1'b0}};
               ptr_d   = next_idx(owner_q);
               state_d = ARB_IDLE;
            end
         end
         ARB_DONE: begin
            ack_d   = {NUM_REQ{1'b0}};
            gnt_d   = {NUM_REQ{1'b0}};
            ptr_d   = next_idx(owner_q);
            state_d = ARB_IDLE;
         end
         default: begin
            // Unused encoding: recover to IDLE with no grant or ack.
            gnt_d   = {NUM_REQ{1'b0}};
            ack_d   = {NUM_REQ{1'b0}};
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= ARB_IDLE;
         ptr_q   <= {IDX_W{1'b0}};
         owner_q <= {IDX_W{1'b0}};
         gnt_q   <= {NUM_REQ{1'b0}};
         ack_q   <= {NUM_REQ{1'b0}};
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
      end
   end

   shared_word_reg #(
      .WIDTH (WIDTH)
   ) u_word (
      .clock (clock),
      .clear (clear),
      .load  (load_s),
      .d     (owner_word_s),
      .q     (q)
   );

   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign owner = owner_q;
   assign busy  = (state_q != ARB_IDLE);

endmodule : dff_bank_arbiter

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;

   localparam int NR = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic            clk;
   logic            clear;
   logic [NR-1:0]   req;
   logic [NR*W-1:0] wdata;
   logic [NR-1:0]   gnt;
   logic [NR-1:0]   ack;
   logic [W-1:0]    q;
   logic [IW-1:0]   owner;
   logic            busy;

   int checks;
   int failures;

   // Reference model: transaction-level view of the arbiter.
   // m_phase: 0 = no transaction, 1 = granted awaiting load, 2 = loaded/acked.
   int           m_phase;
   int           m_ptr;
   int           m_owner;
   logic [NR-1:0] m_gnt;
   logic [NR-1:0] m_ack;
   logic [W-1:0]  m_q;

   dff_bank_arbiter #(.NUM_REQ(NR), .WIDTH(W), .IDX_W(IW)) dut (
      .clock (clk),
      .clear (clear),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .owner (owner),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_word(input int i, input logic [W-1:0] v);
      wdata[i*W +: W] = v;
   endtask

   // Advance the model by one clock using the inputs present before the edge.
   task automatic model_step();
      int k;
      if (!clear) begin
         m_phase = 0; m_ptr = 0; m_owner = 0;
         m_gnt = '0;  m_ack = '0; m_q = '0;
      end else if (m_phase == 0) begin
         if (req != '0) begin
            k = 0;
            while (!req[(m_ptr + k) % NR]) k++;
            m_owner = (m_ptr + k) % NR;
            m_gnt   = NR'(1) << m_owner;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (req[m_owner]) begin
            m_q     = wdata[m_owner*W +: W];
            m_ack   = NR'(1) << m_owner;
            m_phase = 2;
         end else begin
            m_gnt   = '0;
            m_ptr   = (m_owner + 1) % NR;
            m_phase = 0;
         end
      end else begin
         m_gnt   = '0;
         m_ack   = '0;
         m_ptr   = (m_owner + 1) % NR;
         m_phase = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_val("gnt",   32'(gnt),   32'(m_gnt));
      check_val("ack",   32'(ack),   32'(m_ack));
      check_val("q",     32'(q),     32'(m_q));
      check_val("owner", 32'(owner), 32'(m_owner));
      check_val("busy",  32'(busy),  32'(m_phase != 0));
      check_val("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
      check_val("ack_implies_gnt", 32'((ack & ~gnt) == '0), 32'd1);
   endtask

   task automatic do_reset();
      clear = 1'b0;
      tick();
      tick();
      clear = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_phase = 0; m_ptr = 0; m_owner = 0;
      m_gnt = '0; m_ack = '0; m_q = '0;
      clear = 1'b0;
      req   = '0;
      wdata = '0;

      // 1 Reset with all requests high
      req = 4'b1111;
      do_reset();
      check_val("rst_gnt",   32'(gnt),   32'd0);
      check_val("rst_ack",   32'(ack),   32'd0);
      check_val("rst_q",     32'(q),     32'd0);
      check_val("rst_owner", 32'(owner), 32'd0);
      check_val("rst_busy",  32'(busy),  32'd0);

      // 2 Single request
      req = 4'b0100;
      set_word(2, 8'hA5);
      tick();
      check_val("single_gnt", 32'(gnt), 32'h4);
      tick();
      check_val("single_q",   32'(q),   32'hA5);
      check_val("single_ack", 32'(ack), 32'h4);
      req = 4'b0000;
      tick();
      check_val("single_gnt_low", 32'(gnt),   32'd0);
      check_val("single_ack_low", 32'(ack),   32'd0);
      check_val("single_owner",   32'(owner), 32'd2);

      // 3 Fairness with all requests held
      req = 4'b0000;
      do_reset();
      for (int i = 0; i < NR; i++) set_word(i, 8'(8'h10 + i));
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         check_val("fair_gnt", 32'(gnt), 32'(1 << (n % NR)));
         tick();
         check_val("fair_q", 32'(q), 32'(8'h10 + (n % NR)));
         tick();
         check_val("fair_idle_gnt", 32'(gnt), 32'd0);
      end
      req = 4'b0000;
      tick();

      // 4 Abort then wrap-around grant order
      do_reset();
      req = 4'b0010;
      set_word(1, 8'h5C);
      tick();
      check_val("abort_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      tick();
      check_val("abort_no_ack", 32'(ack), 32'd0);
      check_val("abort_q",      32'(q),   32'd0);
      check_val("abort_busy",   32'(busy), 32'd0);
      req = 4'b0011;
      set_word(0, 8'h3E);
      tick();
      check_val("abort_next_gnt0", 32'(gnt), 32'h1);
      tick();
      check_val("abort_q0", 32'(q), 32'h3E);
      req = 4'b0010;
      tick();
      tick();
      check_val("abort_then_gnt1", 32'(gnt), 32'h2);
      tick();
      check_val("abort_q1", 32'(q), 32'h5C);
      req = 4'b0000;
      tick();

      // 5 Reset in the middle of a transaction
      do_reset();
      req = 4'b1000;
      set_word(3, 8'hFF);
      tick();
      check_val("midrst_gnt", 32'(gnt), 32'h8);
      clear = 1'b0;
      tick();
      check_val("midrst_q",    32'(q),    32'd0);
      check_val("midrst_ack",  32'(ack),  32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      clear = 1'b1;
      req = 4'b1001;
      tick();
      check_val("midrst_next_gnt", 32'(gnt), 32'h1);
      tick();
      req = 4'b1000;
      tick();
      tick();
      tick();
      req = 4'b0000;
      tick();

      // 6 Pointer wrap after serving the last requester
      do_reset();
      req = 4'b1000;
      set_word(3, 8'h77);
      tick();
      tick();
      check_val("wrap_q", 32'(q), 32'h77);
      req = 4'b1001;
      set_word(0, 8'h11);
      tick();
      tick();
      check_val("wrap_gnt0", 32'(gnt), 32'h1);
      tick();
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      tick();

      // Randomized traffic: requesters hold until ack, occasionally abort,
      // data changes at random, occasional resets.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
            end else if (gnt[i] && ($urandom % 8) == 0) begin
               req[i] = 1'b0;
            end else if (!req[i] && ($urandom % 3) == 0) begin
               req[i] = 1'b1;
               set_word(i, 8'($urandom));
            end
            if (($urandom % 4) == 0) set_word(i, 8'($urandom));
         end
         clear = (($urandom % 64) == 0) ? 1'b0 : 1'b1;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dff_bank_arbiter
